clk_div_prog: RTL and testbench
===============================

# clk_div_prog

Multi-channel programmable integer clock divider, the parametrised successor to the fixed power-of-two ripple divider. All channels run from one source clock with no ripple clocking. Each channel divides by any runtime integer 2..2^CNT_W-1 and accepts divisor changes through a valid/ready port. Changes apply only at period boundaries, so no output ever shows a runt pulse. Outputs feed local clock-enable logic, test-clock pins and low-rate peripheral clocks.

## Interface
- NUM_CH, 2: number of independent divider channels (1..16).
- CNT_W, 8: divisor and counter width in bits.
- DEF_DIV, 8: divisor loaded into every channel at reset (0..2^CNT_W-1).

- clk  input  1  source clock; the single clock of the block.
- rst_b  input  1  asynchronous active-low reset.
- div_vld  input  1  divisor update request.
- div_rdy  output  1  update port ready; a transfer occurs when div_vld & div_rdy at a clk rising edge.
- div_ch  input  $clog2(NUM_CH) (min 1)  target channel of the update.
- div_val  input  CNT_W  new divisor N; values 0 and 1 stop the channel.
- out_clk  output  NUM_CH  divided clocks, one bit per channel, driven directly from flops.
- tick  output  NUM_CH  one-clk-cycle pulse per channel, high in the cycle in which out_clk rises.

## Operation
- Per-channel state: active divisor div_q, counter cnt (0..div_q-1), started flag, pending valid pend_v, pending value pend_d.
- High phase length H = div_q>>1 cycles; out_clk=1 while cnt<H, else 0.
- Running channel (div_q>=2): cnt increments each cycle and wraps to 0 after div_q-1. tick=1 exactly when cnt==0.
- Stopped channel (div_q<2): cnt held 0, out_clk=0, tick=0.
- Start: first edge after rst_b release sets started. Running channels enter cnt=0, which drives out_clk=1 and tick=1.
- div_rdy = ~pend_v[div_ch] (combinational on div_ch). An accepted request sets pend_v and pend_d for that channel.
- Apply point for a running channel is the edge where cnt wraps (cnt==div_q-1). At that edge div_q<=pend_d, cnt<=0 and pend_v clears.
- If acceptance and wrap occur on the same edge, the new divisor applies directly to the period starting at that edge; pend_v stays 0.
- Stopped channel: pending value applies on the edge after acceptance. If that value is >=2, the channel starts with cnt=0 and tick=1.
- Divisor 0 or 1 written to a running channel: the current period completes, then the output stays low.
- Channels are fully independent. An update to channel a never perturbs the phase of channel b.

## Timing
- Reset values: out_clk=0, tick=0, div_rdy=1, cnt=0, div_q=DEF_DIV, pend_v=0, started=0.
- Reset mid-operation clears all state asynchronously, including pending updates. Outputs go low immediately.
- Period of out_clk = N clk cycles. High = floor(N/2) cycles, low = ceil(N/2) cycles (without the macro).
- Start latency: out_clk first rises at the 1st clk edge after rst_b deasserts.
- Update latency: at most div_q_old cycles from acceptance to the new period starting.
- A second update to the same channel while pend_v=1 is back-pressured (div_rdy=0). It is never dropped or overwritten.

## Configuration
- DIVCLK_ODD_DUTY50_EN defined: each channel adds a negedge-clk flop that copies the posedge high-phase flop. For odd N, out_clk = pos_high | neg_high, giving exactly 50% duty (high N/2 cycles). For even N the negedge flop is unused, and out_clk is identical to the undefined case.
- Undefined: no negedge flops, all logic on posedge clk, odd N duty = floor(N/2)/N.

## Test plan
- Reset with DEF_DIV=8, NUM_CH=2 -> both out_clk rise 1 cycle after release, period 8, high 4; tick pulses every 8th cycle.
- Write ch0=5 mid-period -> current 8-cycle period completes; the next period is 5 cycles, high 2 (or 2.5 with DIVCLK_ODD_DUTY50_EN); ch1 phase unchanged.
- Write ch1=3 and, on the next cycle, ch1=6 -> div_rdy=0 for the second request until the wrap; sequence 8, then 3, then 6; no value lost.
- Write ch0=0 -> out_clk low after the current period completes, tick silent. Then write ch0=2 -> out_clk high on the next cycle, toggling every cycle.
- Assert rst_b low mid-high-phase with ch0 pending update 7 -> out_clk=0 immediately; after release, period=DEF_DIV and the pending value is discarded.
- Acceptance on the wrap edge (write 4 while cnt==div_q-1) -> the very next period is 4 cycles; div_rdy stays 1.

Source files
------------

// File: rtl/clk_div_prog_if.sv
// Divisor update port of clk_div_prog: valid/ready transfer of a channel index and a new divisor.
interface clk_div_prog_if #(
   parameter int NUM_CH = 2,
   parameter int CNT_W  = 8
);
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic             div_vld;
   logic             div_rdy;
   logic [CH_W-1:0]  div_ch;
   logic [CNT_W-1:0] div_val;

   modport master (
      output div_vld,
      output div_ch,
      output div_val,
      input  div_rdy
   );

   modport slave (
      input  div_vld,
      input  div_ch,
      input  div_val,
      output div_rdy
   );
endinterface

// File: rtl/clk_div_prog.sv
// Multi-channel programmable integer clock divider; divisor changes take effect only at period boundaries.
// Optional macro DIVCLK_ODD_DUTY50_EN adds a negedge flop per channel for 50% duty on odd divisors.
module clk_div_prog #(
   parameter int NUM_CH  = 2,
   parameter int CNT_W   = 8,
   parameter int DEF_DIV = 8
) (
   input  logic              clk,
   input  logic              rst_b,
   clk_div_prog_if.slave     div_if,
   output logic [NUM_CH-1:0] out_clk,
   output logic [NUM_CH-1:0] tick
);
   localparam int               CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int               PAD_N = 1 << CH_W;
   localparam logic [CNT_W-1:0] DEF_Q = CNT_W'(DEF_DIV);
   localparam logic [CNT_W-1:0] ONE_Q = CNT_W'(1);
   localparam logic [CNT_W-1:0] TWO_Q = CNT_W'(2);

   logic                 started_r;
   logic [CNT_W-1:0]     div_q_r  [NUM_CH];
   logic [CNT_W-1:0]     cnt_r    [NUM_CH];
   logic [CNT_W-1:0]     pend_d_r [NUM_CH];
   logic [NUM_CH-1:0]    pend_v_r;
   logic [NUM_CH-1:0]    out_pos_r;
   logic [NUM_CH-1:0]    tick_r;

   logic [CNT_W-1:0]     div_q_s  [NUM_CH];
   logic [CNT_W-1:0]     cnt_s    [NUM_CH];
   logic [CNT_W-1:0]     pend_d_s [NUM_CH];
   logic [NUM_CH-1:0]    pend_v_s;
   logic [NUM_CH-1:0]    out_pos_s;
   logic [NUM_CH-1:0]    tick_s;
   logic [NUM_CH-1:0]    acc_s;
   logic [PAD_N-1:0]     pend_pad_s;
   logic                 rdy_s;

   // Ready lookup; indices beyond NUM_CH read as ready and address no channel.
   always_comb begin
      pend_pad_s               = {PAD_N{1'b0}};
      pend_pad_s[NUM_CH-1:0]   = pend_v_r;
      rdy_s                    = ~pend_pad_s[div_if.div_ch];
   end

   assign div_if.div_rdy = rdy_s;

   // Per-channel next state: count, wrap, apply pending divisor, derive next output levels.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         acc_s[i]    = div_if.div_vld & rdy_s & (div_if.div_ch == CH_W'(i));
         div_q_s[i]  = div_q_r[i];
         cnt_s[i]    = cnt_r[i];
         pend_v_s[i] = pend_v_r[i];
         pend_d_s[i] = pend_d_r[i];

         if (!started_r) begin
            cnt_s[i] = {CNT_W{1'b0}};
            if (acc_s[i]) begin
               pend_v_s[i] = 1'b1;
               pend_d_s[i] = div_if.div_val;
            end else begin
               pend_v_s[i] = pend_v_r[i];
            end
         end else if (div_q_r[i] < TWO_Q) begin
            // Stopped: a pending value is applied on the very next edge.
            cnt_s[i] = {CNT_W{1'b0}};
            if (pend_v_r[i]) begin
               div_q_s[i]  = pend_d_r[i];
               pend_v_s[i] = 1'b0;
            end else if (acc_s[i]) begin
               pend_v_s[i] = 1'b1;
               pend_d_s[i] = div_if.div_val;
            end else begin
               pend_v_s[i] = pend_v_r[i];
            end
         end else if (cnt_r[i] == (div_q_r[i] - ONE_Q)) begin
            // Period boundary: a request accepted on this edge bypasses the pending slot.
            cnt_s[i] = {CNT_W{1'b0}};
            if (pend_v_r[i]) begin
               div_q_s[i]  = pend_d_r[i];
               pend_v_s[i] = 1'b0;
            end else if (acc_s[i]) begin
               div_q_s[i]  = div_if.div_val;
            end else begin
               div_q_s[i]  = div_q_r[i];
            end
         end else begin
            cnt_s[i] = cnt_r[i] + ONE_Q;
            if (acc_s[i]) begin
               pend_v_s[i] = 1'b1;
               pend_d_s[i] = div_if.div_val;
            end else begin
               pend_v_s[i] = pend_v_r[i];
            end
         end

         out_pos_s[i] = (div_q_s[i] >= TWO_Q) && (cnt_s[i] < (div_q_s[i] >> 1));
         tick_s[i]    = (div_q_s[i] >= TWO_Q) && (cnt_s[i] == {CNT_W{1'b0}});
      end
   end

   // State and output flops; reset also discards any pending update.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         started_r <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) begin
            div_q_r[i]  <= DEF_Q;
            cnt_r[i]    <= {CNT_W{1'b0}};
            pend_d_r[i] <= {CNT_W{1'b0}};
         end
         pend_v_r  <= {NUM_CH{1'b0}};
         out_pos_r <= {NUM_CH{1'b0}};
         tick_r    <= {NUM_CH{1'b0}};
      end else begin
         started_r <= 1'b1;
         for (int i = 0; i < NUM_CH; i++) begin
            div_q_r[i]  <= div_q_s[i];
            cnt_r[i]    <= cnt_s[i];
            pend_d_r[i] <= pend_d_s[i];
         end
         pend_v_r  <= pend_v_s;
         out_pos_r <= out_pos_s;
         tick_r    <= tick_s;
      end
   end

   assign tick = tick_r;

`ifdef DIVCLK_ODD_DUTY50_EN
   logic [NUM_CH-1:0] out_neg_r;
   logic [NUM_CH-1:0] odd_s;

   // Half-cycle delayed copy of the high phase, used only for odd divisors.
   always_ff @(negedge clk or negedge rst_b) begin
      if (!rst_b) begin
         out_neg_r <= {NUM_CH{1'b0}};
      end else begin
         out_neg_r <= out_pos_r;
      end
   end

   // Odd flag follows the divisor of the period currently on the output.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         odd_s[i] = div_q_r[i][0];
      end
   end

   assign out_clk = out_pos_r | (out_neg_r & odd_s);
`else
   assign out_clk = out_pos_r;
`endif

endmodule

// File: tb/tb_clk_div_prog.sv
// Scoreboard bench for clk_div_prog: a period-level reference model predicts out_clk/tick/div_rdy per edge.
module tb_clk_div_prog;
   localparam int NUM_CH  = 2;
   localparam int CNT_W   = 8;
   localparam int DEF_DIV = 8;
   localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   typedef struct packed {
      logic [NUM_CH-1:0] oc;
      logic [NUM_CH-1:0] tk;
      logic              rdy;
   } exp_t;

   logic              clk;
   logic              rst_b;
   logic [NUM_CH-1:0] out_clk;
   logic [NUM_CH-1:0] tick;

   int   checks;
   int   errors;
   exp_t exp_q[$];

   // Reference model: each running channel is a period of m_len cycles that began at edge m_start.
   int m_k;
   int m_run   [NUM_CH];
   int m_len   [NUM_CH];
   int m_start [NUM_CH];
   int m_pv    [NUM_CH];
   int m_pd    [NUM_CH];

   clk_div_prog_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bif ();

   clk_div_prog #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEF_DIV(DEF_DIV)) dut (
      .clk     (clk),
      .rst_b   (rst_b),
      .div_if  (bif),
      .out_clk (out_clk),
      .tick    (tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_k = 0;
      for (int c = 0; c < NUM_CH; c++) begin
         m_run[c]   = 0;
         m_len[c]   = DEF_DIV;
         m_start[c] = 0;
         m_pv[c]    = 0;
         m_pd[c]    = 0;
      end
   endtask

   task automatic model_edge(input int c, input bit acc, input int val);
      int nl;
      if (m_k == 1) begin
         m_run[c]   = (DEF_DIV >= 2) ? 1 : 0;
         m_start[c] = 1;
         if (acc) begin m_pv[c] = 1; m_pd[c] = val; end
      end else if (m_run[c] != 0) begin
         if (m_k - m_start[c] == m_len[c]) begin
            nl = (m_pv[c] != 0) ? m_pd[c] : (acc ? val : m_len[c]);
            m_pv[c]    = 0;
            m_len[c]   = nl;
            m_start[c] = m_k;
            m_run[c]   = (nl >= 2) ? 1 : 0;
         end else if (acc) begin
            m_pv[c] = 1; m_pd[c] = val;
         end
      end else begin
         if (m_pv[c] != 0) begin
            m_len[c]   = m_pd[c];
            m_pv[c]    = 0;
            m_start[c] = m_k;
            m_run[c]   = (m_pd[c] >= 2) ? 1 : 0;
         end else if (acc) begin
            m_pv[c] = 1; m_pd[c] = val;
         end
      end
   endtask

   // Drive one cycle of inputs, advance the model by one edge, queue the expected response.
   task automatic step(input bit vld, input int ch, input int val, output bit accepted);
      exp_t e;
      bif.div_vld = vld;
      bif.div_ch  = CH_W'(ch);
      bif.div_val = CNT_W'(val);
      accepted = vld && (m_pv[ch] == 0);
      m_k++;
      for (int c = 0; c < NUM_CH; c++) begin
         model_edge(c, accepted && (c == ch), val);
         e.oc[c] = (m_run[c] != 0) && ((m_k - m_start[c]) < (m_len[c] / 2));
         e.tk[c] = (m_run[c] != 0) && (m_k == m_start[c]);
      end
      e.rdy = (m_pv[ch] == 0);
      exp_q.push_back(e);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      bit a;
      for (int j = 0; j < n; j++) step(1'b0, 0, 0, a);
   endtask

   task automatic send(input int ch, input int val);
      bit a;
      bit done;
      done = 1'b0;
      for (int j = 0; j < 64 && !done; j++) begin
         step(1'b1, ch, val, a);
         done = a;
      end
      if (!done) begin
         errors++;
         $display("FAIL send_timeout: ch %0d val %0d not accepted within 64 cycles", ch, val);
      end
      idle(1);
   endtask

   // Monitor: one queued expectation per clock edge, sampled just after the edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("out_clk", 32'(out_clk), 32'(e.oc));
            chk("tick", 32'(tick), 32'(e.tk));
            chk("div_rdy", 32'(bif.div_rdy), 32'(e.rdy));
         end
      end
   end

   initial begin
      bit a;
      bit hit;
      checks = 0;
      errors = 0;
      rst_b  = 1'b0;
      bif.div_vld = 1'b0;
      bif.div_ch  = '0;
      bif.div_val = '0;
      model_reset();

      repeat (3) @(negedge clk);
      chk("reset_out_clk", 32'(out_clk), 32'd0);
      chk("reset_tick", 32'(tick), 32'd0);
      chk("reset_div_rdy", 32'(bif.div_rdy), 32'd1);
      rst_b = 1'b1;

      // Start-up: both channels at DEF_DIV.
      idle(19);

      // ch0 = 5 written mid-period.
      hit = 1'b0;
      for (int j = 0; j < 64 && !hit; j++) begin
         if (m_k - m_start[0] == 3) hit = 1'b1; else idle(1);
      end
      chk("reach_mid_period", 32'(hit), 32'd1);
      send(0, 5);
      idle(20);

      // ch1 = 3 then ch1 = 6 back-to-back; second is back-pressured.
      step(1'b1, 1, 3, a);
      chk("ch1_first_accept", 32'(a), 32'd1);
      send(1, 6);
      idle(25);

      // ch0 stopped, then restarted at divisor 2.
      send(0, 0);
      idle(15);
      send(0, 2);
      idle(8);

      // Acceptance exactly on ch1's wrap edge.
      hit = 1'b0;
      for (int j = 0; j < 64 && !hit; j++) begin
         if ((m_run[1] != 0) && (m_pv[1] == 0) && (m_k + 1 - m_start[1] == m_len[1])) hit = 1'b1;
         else idle(1);
      end
      chk("reach_wrap_edge", 32'(hit), 32'd1);
      step(1'b1, 1, 4, a);
      chk("wrap_accept", 32'(a), 32'd1);
      idle(12);

      // Reset mid-high-phase with a pending update on ch0.
      send(0, 9);
      hit = 1'b0;
      for (int j = 0; j < 64 && !hit; j++) begin
         if ((m_len[0] == 9) && (m_run[0] != 0) && (m_k == m_start[0])) hit = 1'b1;
         else idle(1);
      end
      chk("reach_high_phase", 32'(hit), 32'd1);
      step(1'b1, 0, 7, a);
      chk("pend7_accept", 32'(a), 32'd1);
      bif.div_vld = 1'b0;
      #2;
      rst_b = 1'b0;
      #1;
      chk("async_reset_out_clk", 32'(out_clk), 32'd0);
      chk("async_reset_tick", 32'(tick), 32'd0);
      chk("async_reset_div_rdy", 32'(bif.div_rdy), 32'd1);
      repeat (2) @(negedge clk);
      rst_b = 1'b1;
      model_reset();
      idle(20);

      // Randomized traffic.
      for (int j = 0; j < 600; j++) begin
         step(($urandom_range(0, 99) < 25), $urandom_range(0, NUM_CH - 1), $urandom_range(0, 12), a);
      end
      idle(30);

      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
